clock_divider_multi: RTL
========================

# clock_divider_multi

Parametrised, multi-channel clock-enable generator, the successor to the single fixed divide-by-100 divider. Each of `N_CH` channels has a runtime-programmable divide value, a toggle (50 % square) or pulse (one-cycle strobe) mode, and an individual enable. A global sync input phase-aligns all channels. It sits between the system clock and the FSM/light-stand timing logic, which consumes `o_tick` as a clock enable.

## Interface
- `N_CH`, 4: number of independent channels (1..16).
- `CNT_W`, 16: counter and divide-value width.
- `DEFAULT_DIV`, 50: divide value loaded on reset. Must be nonzero and fit in `CNT_W`.
- `i_clk`  input  1: system clock; all logic on rising edge.
- `i_reset_n`  input  1: asynchronous, active-low reset.
- `i_en`  input  N_CH: per-channel enable.
- `i_sync`  input  1: single-cycle strobe that restarts all channels in phase.
- `i_wr`  input  1: write strobe for the divide/mode configuration.
- `i_wr_ch`  input  $clog2(N_CH) (min 1): target channel of the write.
- `i_wr_div`  input  CNT_W: new divide value D.
- `i_wr_mode`  input  1: new mode. 0 = toggle, 1 = pulse.
- `o_clk`  output  N_CH: divided clock per channel (registered).
- `o_tick`  output  N_CH: one-cycle strobe at each channel wrap (registered).

## Operation
Per-channel state:
- `cnt`, width CNT_W.
- Active `div` and `mode`.
- Shadow `div_s` and `mode_s`.
- Output registers `clk_q` and `tick_q`.

Reset (`i_reset_n` = 0, asynchronous):
- `cnt` = 0, `clk_q` = 0, `tick_q` = 0.
- `div` = `div_s` = DEFAULT_DIV; `mode` = `mode_s` = 0.

Configuration write: when `i_wr` = 1, `div_s[i_wr_ch]` <= `i_wr_div` and `mode_s[i_wr_ch]` <= `i_wr_mode`.
- A written D = 0 is stored as 1.
- A write with `i_wr_ch` >= N_CH is ignored.

Per-channel update at each edge, in priority order (first match wins):
1. `i_en` = 0: `cnt` <= 0, `clk_q` <= 0, `tick_q` <= 0; active <= shadow (loaded every cycle while disabled).
2. `i_sync` = 1: `cnt` <= 0, `clk_q` <= 0, `tick_q` <= 0; active <= shadow.
3. `cnt` == `div` - 1 (wrap): `cnt` <= 0, `tick_q` <= 1; active <= shadow.
   - Toggle mode: `clk_q` <= ~`clk_q`.
   - Pulse mode: `clk_q` <= 1.
   - The mode used for `clk_q` is the pre-edge active mode.
   - If active mode changes at this edge, `clk_q` <= 0 instead.
4. Otherwise: `cnt` <= `cnt` + 1, `tick_q` <= 0.
   - Pulse mode: `clk_q` <= 0. Toggle mode: `clk_q` holds.

Shadow-to-active transfer always uses the shadow value registered before the edge. Consequences:
- A write in the same cycle as a wrap, sync or disable takes effect at the following boundary.
- Divide changes are glitch-free: a period in progress always completes with the old D.

Sizing: `cnt` never exceeds `div` - 1; no overflow is possible. D = 2^CNT_W - 1 is the largest divide value.

## Timing
- Output periods:
  - Toggle mode: `o_clk` period 2·D cycles, 50 % duty.
  - Pulse mode: `o_clk` high 1 cycle in D; `o_tick` period D.
- First-edge latency: with `cnt` = 0 and enable high, the first `o_tick`/`o_clk` change is visible after the D-th rising edge.
- D = 1:
  - `o_tick` is constantly high.
  - Toggle: `o_clk` toggles every cycle.
  - Pulse: `o_clk` is constantly high.
- Sync: channels enabled and synced in the same cycle, with equal D, stay cycle-aligned thereafter.
- Disable mid-period: outputs are forced low on the next edge. Re-enable restarts a full period.
- Reset mid-operation: outputs are low immediately, independent of the clock. Programmed values are lost and revert to DEFAULT_DIV.

## Test plan
- Reset, then `i_en` = all ones, no writes → every `o_clk` rises after edge 50 and falls after edge 100 (period 100); `o_tick` pulses at edges 50, 100, 150.
- Write ch1 D = 3, mode 1 while ch1 is disabled, then enable → `o_clk[1]` = `o_tick[1]` high one cycle every 3, first after edge 3.
- Ch0 running D = 50; write D = 10 at `cnt` = 20 → current period ends at edge 50 as before; next half-periods are 10 cycles.
- Write D = 0 to ch2, toggle mode → behaves as D = 1: `o_clk[2]` toggles every cycle, `o_tick[2]` stuck high.
- Ch0 D = 4, ch3 D = 4 at different phases; pulse `i_sync` → both `o_clk` go 0, then toggle together at sync + 4 and sync + 8.
- Assert `i_reset_n` low mid-period, asynchronously, between edges → all outputs 0 before the next edge; after release, D = 50 is restored; a write with `i_wr_ch` = N_CH changes nothing.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock-enable generator (toggle or pulse mode per channel).
// Latency: outputs registered; first tick/clk change visible after the D-th enabled edge.
// No backpressure: free-running; config writes land in a shadow and apply at the next period boundary.
module clock_divider_multi #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 50,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [N_CH-1:0]   i_en,
    input  logic              i_sync,
    input  logic              i_wr,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [CNT_W-1:0]  i_wr_div,
    input  logic              i_wr_mode,
    output logic [N_CH-1:0]   o_clk,
    output logic [N_CH-1:0]   o_tick
);

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    // Per-channel state: counter, active config, shadow config, output registers
    logic [N_CH-1:0][CNT_W-1:0] cnt_q,   cnt_d;
    logic [N_CH-1:0][CNT_W-1:0] div_q,   div_d;
    logic [N_CH-1:0][CNT_W-1:0] div_s_q, div_s_d;
    logic [N_CH-1:0]            mode_q,   mode_d;
    logic [N_CH-1:0]            mode_s_q, mode_s_d;
    logic [N_CH-1:0]            clk_q,    clk_d;
    logic [N_CH-1:0]            tick_q,   tick_d;

    // Shadow config capture; out-of-range channel numbers match no loop index and are dropped
    always_comb begin
        div_s_d  = div_s_q;
        mode_s_d = mode_s_q;
        for (int i = 0; i < N_CH; i++) begin
            if (i_wr && (i_wr_ch == CH_W'(i))) begin
                // D = 0 would make the wrap compare underflow; treat it as divide-by-one
                div_s_d[i]  = (i_wr_div == '0) ? ONE : i_wr_div;
                mode_s_d[i] = i_wr_mode;
            end
        end
    end

    // Per-channel counter/output update; shadow->active only at disable, sync or wrap
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        mode_d = mode_q;
        clk_d  = clk_q;
        tick_d = tick_q;
        for (int i = 0; i < N_CH; i++) begin
            if (!i_en[i] || i_sync) begin
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
                tick_d[i] = 1'b0;
                div_d[i]  = div_s_q[i];
                mode_d[i] = mode_s_q[i];
            end else if (cnt_q[i] == (div_q[i] - ONE)) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                div_d[i]  = div_s_q[i];
                mode_d[i] = mode_s_q[i];
                // A mode switch restarts the output low so the new mode starts from a clean phase
                if (mode_s_q[i] != mode_q[i]) begin
                    clk_d[i] = 1'b0;
                end else if (mode_q[i]) begin
                    clk_d[i] = 1'b1;
                end else begin
                    clk_d[i] = ~clk_q[i];
                end
            end else begin
                cnt_d[i]  = cnt_q[i] + ONE;
                tick_d[i] = 1'b0;
                clk_d[i]  = mode_q[i] ? 1'b0 : clk_q[i];
            end
        end
    end

    // State registers with asynchronous reset back to the default divide
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q    <= '0;
            div_q    <= {N_CH{DEF_DIV}};
            div_s_q  <= {N_CH{DEF_DIV}};
            mode_q   <= '0;
            mode_s_q <= '0;
            clk_q    <= '0;
            tick_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            div_s_q  <= div_s_d;
            mode_q   <= mode_d;
            mode_s_q <= mode_s_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    assign o_clk  = clk_q;
    assign o_tick = tick_q;

endmodule
